// File: rtl/gray_bus_rx.sv
// rtl/gray_bus_rx.sv - Gray-coded bus receiver with sync, stability filter, step classification
module gray_bus_rx #(
    parameter int BITS          = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BITS-1:0]  gray_in,
    input  logic             enable,
    input  logic             clear,
    output logic [BITS-1:0]  bin_out,
    output logic             value_valid,
    output logic             step_up,
    output logic             step_down,
    output logic             skip_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0][BITS-1:0] sync_q;
    logic [BITS-1:0]  sync_word;
    logic [BITS-1:0]  cand;
    logic [CNT_W-1:0] stab_cnt;
    logic             accept;
    logic [BITS-1:0]  dec;
    logic [BITS-1:0]  diff;

    logic [BITS-1:0]  bin_nxt;
    logic             valid_nxt;
    logic             up_nxt;
    logic             down_nxt;
    logic             skip_nxt;
    logic [ERR_W-1:0] err_nxt;

    // Plain flop chain: nothing may sit between the metastability stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
        end
    end

    assign sync_word = sync_q[SYNC_STAGES-1];

    // Accept fires on the edge where stab_cnt would reach STABLE_CYCLES, so only once per candidate.
    assign accept = enable && !clear && (sync_word == cand)
                    && (stab_cnt == CNT_W'(STABLE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand     <= '0;
            stab_cnt <= '0;
        end else if (clear) begin
            stab_cnt <= '0;
        end else if (enable) begin
            if (sync_word != cand) begin
                cand     <= sync_word;
                stab_cnt <= '0;
            end else if (stab_cnt < CNT_W'(STABLE_CYCLES)) begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
        end
    end

    // Binary bit i is the XOR of all Gray bits from i upward.
    always_comb begin
        dec = '0;
        for (int i = 0; i < BITS; i++) begin
            dec[i] = ^(cand >> i);
        end
    end

    assign diff = dec - bin_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= UNLOCKED;
            bin_out     <= '0;
            value_valid <= 1'b0;
            step_up     <= 1'b0;
            step_down   <= 1'b0;
            skip_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            bin_out     <= bin_nxt;
            value_valid <= valid_nxt;
            step_up     <= up_nxt;
            step_down   <= down_nxt;
            skip_err    <= skip_nxt;
            err_count   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = UNLOCKED;
        end else if (accept) begin
            state_nxt = LOCKED;
        end
    end

    always_comb begin
        bin_nxt   = bin_out;
        valid_nxt = value_valid;
        up_nxt    = 1'b0;
        down_nxt  = 1'b0;
        skip_nxt  = 1'b0;
        err_nxt   = err_count;
        if (clear) begin
            valid_nxt = 1'b0;
            err_nxt   = '0;
        end else if (accept) begin
            bin_nxt   = dec;
            valid_nxt = 1'b1;
            // diff of zero means the bus glitched away and came back: silent re-accept.
            if (state == LOCKED) begin
                if (diff == BITS'(1)) begin
                    up_nxt = 1'b1;
                end else if (diff == {BITS{1'b1}}) begin
                    down_nxt = 1'b1;
                end else if (diff != '0) begin
                    skip_nxt = 1'b1;
                    if (err_count != {ERR_W{1'b1}}) begin
                        err_nxt = err_count + ERR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_bus_rx.sv
// tb/tb_gray_bus_rx.sv - self-checking bench for gray_bus_rx
module tb_gray_bus_rx;

    localparam int BITS   = 5;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int ERR_W  = 8;
    localparam int MODV   = 1 << BITS;
    localparam int ERRMAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [BITS-1:0]  gray_in;
    logic             enable;
    logic             clear;
    logic [BITS-1:0]  bin_out;
    logic             value_valid;
    logic             step_up;
    logic             step_down;
    logic             skip_err;
    logic [ERR_W-1:0] err_count;

    gray_bus_rx #(
        .BITS(BITS), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .enable(enable), .clear(clear),
        .bin_out(bin_out), .value_valid(value_valid), .step_up(step_up),
        .step_down(step_down), .skip_err(skip_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cnt_up, cnt_down, cnt_skip;

    int m_sync [SYNC];
    int m_cand, m_run, m_bin, m_err;
    bit m_locked, m_valid, m_up, m_down, m_skip;

    typedef struct {
        int val;
        int hold;
        int en;
        int clr;
        int exp_bin;
        int exp_up;
        int exp_down;
        int exp_skip;
        int exp_err;
    } vec_t;

    vec_t vecs [17];

    function automatic logic [BITS-1:0] to_gray(input int b);
        return BITS'(b ^ (b >> 1));
    endfunction

    function automatic int from_gray(input int g);
        for (int b = 0; b < MODV; b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input int v);
        int d;
        if (!m_locked) begin
            m_locked = 1'b1;
            m_valid  = 1'b1;
        end else begin
            d = (v - m_bin + MODV) % MODV;
            if (d == 1) m_up = 1'b1;
            else if (d == MODV - 1) m_down = 1'b1;
            else if (d != 0) begin
                m_skip = 1'b1;
                if (m_err < ERRMAX) m_err++;
            end
        end
        m_bin = v;
    endtask

    task automatic model_step();
        int sw;
        m_up = 1'b0; m_down = 1'b0; m_skip = 1'b0;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_sync[i] = 0;
            m_cand = 0; m_run = 0; m_locked = 1'b0; m_bin = 0; m_valid = 1'b0; m_err = 0;
        end else begin
            sw = m_sync[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = int'(gray_in);
            if (clear) begin
                m_locked = 1'b0; m_valid = 1'b0; m_err = 0; m_run = 0;
            end else if (enable) begin
                if (sw != m_cand) begin
                    m_cand = sw;
                    m_run  = 0;
                end else if (m_run < STABLE) begin
                    m_run++;
                    if (m_run == STABLE) model_accept(from_gray(sw));
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("model_bin", int'(bin_out), m_bin);
        chk("model_valid", int'(value_valid), int'(m_valid));
        chk("model_up", int'(step_up), int'(m_up));
        chk("model_down", int'(step_down), int'(m_down));
        chk("model_skip", int'(skip_err), int'(m_skip));
        chk("model_err", int'(err_count), m_err);
        cnt_up   += int'(step_up);
        cnt_down += int'(step_down);
        cnt_skip += int'(skip_err);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic zero_counts();
        cnt_up = 0; cnt_down = 0; cnt_skip = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int prev;
        int hold;

        // value, hold, enable, clear, bin, ups, downs, skips, err_count
        vecs[0]  = '{5, 10, 1, 0, 5, 1, 0, 0, 0};
        vecs[1]  = '{6, 10, 1, 0, 6, 1, 0, 0, 0};
        vecs[2]  = '{7, 10, 1, 0, 7, 1, 0, 0, 0};
        vecs[3]  = '{31, 10, 1, 0, 31, 0, 0, 1, 1};
        vecs[4]  = '{0, 10, 1, 0, 0, 1, 0, 0, 1};
        vecs[5]  = '{31, 10, 1, 0, 31, 0, 1, 0, 1};
        vecs[6]  = '{4, 10, 1, 0, 4, 0, 0, 1, 2};
        vecs[7]  = '{9, 1, 1, 0, 4, 0, 0, 0, 2};
        vecs[8]  = '{4, 10, 1, 0, 4, 0, 0, 0, 2};
        vecs[9]  = '{9, 2, 1, 0, 4, 0, 0, 0, 2};
        vecs[10] = '{4, 10, 1, 0, 4, 0, 0, 0, 2};
        vecs[11] = '{9, 3, 1, 0, 4, 0, 0, 0, 2};
        vecs[12] = '{4, 10, 1, 0, 4, 0, 0, 0, 2};
        vecs[13] = '{9, 5, 1, 0, 4, 0, 0, 0, 2};
        vecs[14] = '{4, 10, 1, 0, 4, 0, 0, 2, 4};
        vecs[15] = '{0, 10, 1, 1, 0, 0, 0, 0, 0};
        vecs[16] = '{9, 10, 1, 0, 9, 0, 0, 1, 1};

        rst = 1'b1; gray_in = '0; enable = 1'b1; clear = 1'b0;
        zero_counts();
        run(3);
        chk("reset_bin", int'(bin_out), 0);
        chk("reset_valid", int'(value_valid), 0);
        chk("reset_err", int'(err_count), 0);

        // First lock latency from the first sampling edge.
        rst = 1'b0;
        gray_in = 5'b00110;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (value_valid) begin
                n = i;
                break;
            end
        end
        chk("first_lock_latency", n, SYNC + STABLE + 1);
        chk("first_lock_bin", int'(bin_out), 4);
        run(3);
        chk("first_lock_pulses", cnt_up + cnt_down + cnt_skip, 0);

        foreach (vecs[k]) begin
            zero_counts();
            gray_in = to_gray(vecs[k].val);
            enable  = vecs[k].en[0];
            clear   = vecs[k].clr[0];
            cyc();
            clear = 1'b0;
            run(vecs[k].hold - 1);
            chk($sformatf("vec%0d_bin", k), int'(bin_out), vecs[k].exp_bin);
            chk($sformatf("vec%0d_up", k), cnt_up, vecs[k].exp_up);
            chk($sformatf("vec%0d_down", k), cnt_down, vecs[k].exp_down);
            chk($sformatf("vec%0d_skip", k), cnt_skip, vecs[k].exp_skip);
            chk($sformatf("vec%0d_err", k), int'(err_count), vecs[k].exp_err);
            chk($sformatf("vec%0d_valid", k), int'(value_valid), 1);
        end

        // Bus moves to +1 while frozen, then resumes.
        zero_counts();
        gray_in = to_gray(10);
        enable  = 1'b0;
        run(10);
        chk("frozen_bin", int'(bin_out), 9);
        chk("frozen_pulses", cnt_up + cnt_down + cnt_skip, 0);
        enable = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (step_up) begin
                n = i;
                break;
            end
        end
        chk("resume_latency", n, STABLE + 1);
        run(3);
        chk("resume_bin", int'(bin_out), 10);

        // clear lands on the accepting edge.
        zero_counts();
        gray_in = to_gray(11);
        run(SYNC + STABLE);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_accept_up", cnt_up, 0);
        chk("clr_accept_valid", int'(value_valid), 0);
        chk("clr_accept_bin_hold", int'(bin_out), 10);
        run(10);
        chk("clr_relock_bin", int'(bin_out), 11);
        chk("clr_relock_pulses", cnt_up + cnt_down + cnt_skip, 0);

        // Reset lands on the accepting edge.
        gray_in = to_gray(12);
        run(SYNC + STABLE);
        rst = 1'b1;
        cyc();
        chk("rst_accept_up", int'(step_up), 0);
        chk("rst_accept_valid", int'(value_valid), 0);
        chk("rst_accept_bin", int'(bin_out), 0);
        rst = 1'b0;
        zero_counts();
        run(12);
        chk("rst_relock_bin", int'(bin_out), 12);
        chk("rst_relock_pulses", cnt_up + cnt_down + cnt_skip, 0);

        // Saturation of the skip counter.
        gray_in = to_gray(0);
        run(10);
        chk("sat_start_err", int'(err_count), 1);
        zero_counts();
        for (int j = 0; j < 300; j++) begin
            gray_in = to_gray((j % 2 == 0) ? 9 : 0);
            run(8);
        end
        chk("sat_skips", cnt_skip, 300);
        chk("sat_err", int'(err_count), ERRMAX);

        // Randomised segments against the model.
        prev = 0;
        for (int s = 0; s < 400; s++) begin
            case ($urandom_range(0, 3))
                0: prev = (prev + 1) % MODV;
                1: prev = (prev + MODV - 1) % MODV;
                2: prev = int'($urandom_range(0, MODV - 1));
                default: prev = prev;
            endcase
            hold    = int'($urandom_range(1, 10));
            gray_in = to_gray(prev);
            enable  = ($urandom_range(0, 7) != 0);
            clear   = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            cyc();
            clear = 1'b0;
            rst   = 1'b0;
            run(hold - 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
